header_feeder: RTL and testbench

Mining-loop controller that sits directly upstream of the double SHA-256 wrapper and also consumes its result. It buffers a 20-word (80-byte) block header and serves the wrapper's word-request bus, substituting the current nonce at word 19. It starts one double-hash per nonce and checks each result against a leading-zero difficulty. It stops on the first qualifying nonce or when the 32-bit nonce space is exhausted.

---
 rtl/header_feeder_pkg.sv | 27 ++
 rtl/header_feeder_if.sv | 27 ++
 rtl/header_feeder_lzc256.sv | 17 +
 rtl/header_feeder.sv | 178 +++++++++++++++++
 tb/tb_header_feeder.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/header_feeder_pkg.sv
// Shared types and constants for the header_feeder mining-loop controller.
package header_feeder_pkg;

    localparam int          HDR_WORDS  = 20;
    localparam int          NONCE_IDX  = 19;
    localparam logic [31:0] LAST_NONCE = 32'hFFFF_FFFF;
    localparam int          LZC_W      = 9;

    typedef enum logic [2:0] {
        S_LOAD,
        S_READY,
        S_START,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    // Little-endian target view: byte 0 of the hash becomes the most significant byte.
    function automatic logic [255:0] byte_reverse(input logic [255:0] h);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) begin
            r[8*b +: 8] = h[8*(31-b) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/header_feeder_if.sv
// Header load stream plus the word-request / result bus shared with the double SHA-256 wrapper.
interface header_feeder_if;

    logic         ld_valid;
    logic [31:0]  ld_data;
    logic         ld_ready;

    logic         sha_start;
    logic         sha_rq;
    logic [4:0]   sha_addr;
    logic         sha_rdy;
    logic [31:0]  sha_data;
    logic [255:0] sha_hash;
    logic         sha_done;

    // master: header source and hash wrapper side; slave: the feeder itself
    modport master (
        output ld_valid, ld_data, sha_rq, sha_addr, sha_hash, sha_done,
        input  ld_ready, sha_start, sha_rdy, sha_data
    );

    modport slave (
        input  ld_valid, ld_data, sha_rq, sha_addr, sha_hash, sha_done,
        output ld_ready, sha_start, sha_rdy, sha_data
    );

endinterface

// File: rtl/header_feeder_lzc256.sv
// Combinational 256-bit leading-zero counter; an all-zero input yields 256.
module lzc256
    import header_feeder_pkg::*;
(
    input  logic [255:0]     din,
    output logic [LZC_W-1:0] count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        count = LZC_W'(256);
        for (int i = 0; i < 256; i++) begin
            if (din[i]) count = LZC_W'(255 - i);
        end
    end

endmodule

// File: rtl/header_feeder.sv
// Mining-loop controller: buffers an 80-byte header, serves the SHA wrapper, iterates the nonce.
// Define HEADER_FEEDER_LE_CHECK_EN to count leading zeros over the byte-reversed hash.
module header_feeder
    import header_feeder_pkg::*;
#(
    parameter int ZBITS_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    header_feeder_if.slave     bus,
    input  logic               go,
    input  logic               abort,
    input  logic [ZBITS_W-1:0] zbits,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [31:0]        nonce_out,
    output logic [255:0]       hash_out
);

    localparam int CMP_W = (ZBITS_W > LZC_W) ? ZBITS_W : LZC_W;

    state_t             state_q, state_d;
    logic [4:0]         wcnt_q;
    logic [31:0]        hdr_q [HDR_WORDS];
    logic [31:0]        nonce_q;
    logic [ZBITS_W-1:0] zbits_q;
    logic               served19_q;
    logic               rq_hold_q;
    logic [255:0]       hbuf_q;
    logic [255:0]       lzc_in;
    logic [LZC_W-1:0]   lz;
    logic               ld_ready_q;
    logic               sha_rdy_q;
    logic [31:0]        sha_data_q;
    logic               found_q, exhausted_q;
    logic [31:0]        nonce_out_q;
    logic [255:0]       hash_out_q;

    logic               ld_accept, last_word, hash_accept, serve, qualifies;
    logic [31:0]        rd_word;
    logic               sha_start_c, busy_c;

    assign ld_accept   = ld_ready_q && bus.ld_valid && !abort;
    assign last_word   = (wcnt_q == 5'(NONCE_IDX));
    assign hash_accept = (state_q == S_RUN) && bus.sha_done && served19_q;
    // An answer is only issued if the controller is still in RUN next cycle.
    assign serve       = (state_q == S_RUN) && (state_d == S_RUN) && bus.sha_rq && !rq_hold_q;

`ifdef HEADER_FEEDER_LE_CHECK_EN
    assign lzc_in = byte_reverse(hbuf_q);
`else
    assign lzc_in = hbuf_q;
`endif

    lzc256 u_lzc (
        .din   (lzc_in),
        .count (lz)
    );

    assign qualifies = (CMP_W'(lz) >= CMP_W'(zbits_q));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD:  if (ld_accept && last_word) state_d = S_READY;
                S_READY: if (go) state_d = S_START;
                S_START: state_d = S_RUN;
                S_RUN:   if (hash_accept) state_d = S_CHECK;
                S_CHECK: state_d = (qualifies || nonce_q == LAST_NONCE) ? S_DONE : S_START;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_LOAD;
            endcase
        end
    end

    always_comb begin
        sha_start_c = (state_q == S_START);
        busy_c      = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_CHECK);
    end

    always_comb begin
        rd_word = '0;
        if (bus.sha_addr == 5'(NONCE_IDX)) rd_word = nonce_q;
        else if (bus.sha_addr < 5'(NONCE_IDX)) rd_word = hdr_q[bus.sha_addr];
    end

    // NOTE: the header store has no reset; it is always fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (ld_accept) hdr_q[wcnt_q] <= bus.ld_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            nonce_q     <= '0;
            zbits_q     <= '0;
            served19_q  <= 1'b0;
            rq_hold_q   <= 1'b0;
            hbuf_q      <= '0;
            ld_ready_q  <= 1'b0;
            sha_rdy_q   <= 1'b0;
            sha_data_q  <= '0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            nonce_out_q <= '0;
            hash_out_q  <= '0;
        end else begin
            ld_ready_q <= (state_d == S_LOAD);
            sha_rdy_q  <= serve;
            if (serve) sha_data_q <= rd_word;
            // One answer per request: re-arm only after sha_rq has been seen low.
            if (!bus.sha_rq) rq_hold_q <= 1'b0;
            else if (serve)  rq_hold_q <= 1'b1;

            if (abort) begin
                wcnt_q      <= '0;
                found_q     <= 1'b0;
                exhausted_q <= 1'b0;
                served19_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (ld_accept) begin
                            if (last_word) begin
                                wcnt_q  <= '0;
                                nonce_q <= bus.ld_data;
                            end else begin
                                wcnt_q <= wcnt_q + 5'd1;
                            end
                        end
                    end
                    S_READY: if (go) zbits_q <= zbits;
                    S_START: served19_q <= 1'b0;
                    S_RUN: begin
                        if (serve && bus.sha_addr == 5'(NONCE_IDX)) served19_q <= 1'b1;
                        if (hash_accept) hbuf_q <= bus.sha_hash;
                    end
                    S_CHECK: begin
                        if (qualifies) begin
                            found_q     <= 1'b1;
                            nonce_out_q <= nonce_q;
                            hash_out_q  <= hbuf_q;
                        end else if (nonce_q == LAST_NONCE) begin
                            exhausted_q <= 1'b1;
                            nonce_out_q <= LAST_NONCE;
                            hash_out_q  <= hbuf_q;
                        end else begin
                            nonce_q <= nonce_q + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ld_ready  = ld_ready_q;
    assign bus.sha_start = sha_start_c;
    assign bus.sha_rdy   = sha_rdy_q;
    assign bus.sha_data  = sha_data_q;
    assign busy          = busy_c;
    assign found         = found_q;
    assign exhausted     = exhausted_q;
    assign nonce_out     = nonce_out_q;
    assign hash_out      = hash_out_q;

endmodule

// File: tb/tb_header_feeder.sv
// Self-checking bench for header_feeder: a behavioural SHA wrapper plus a nonce-search reference model.
`timescale 1ns/1ps
module tb_header_feeder;

    localparam int HM_ONES   = 0;
    localparam int HM_TARGET = 1;
    localparam int HM_FIXED  = 2;
    localparam int HM_RAND   = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         go, abort;
    logic [8:0]   zbits;
    logic         busy, found, exhausted;
    logic [31:0]  nonce_out;
    logic [255:0] hash_out;

    header_feeder_if bus();

    header_feeder #(.ZBITS_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .go        (go),
        .abort     (abort),
        .zbits     (zbits),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted),
        .nonce_out (nonce_out),
        .hash_out  (hash_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           errors = 0;
    int           checks = 0;
    logic [31:0]  hdr_ref [20];
    int           hmode = HM_ONES;
    logic [31:0]  htarget = '0;
    logic [31:0]  hsalt = '0;
    logic [255:0] hfixed = '0;
    logic [255:0] htarget_hash = '0;
    bit           wrap_auto = 1'b1;
    logic [31:0]  exp_nonce = '0;
    int           n_starts = 0;
    int           done_cyc = 0;

    // Hash the wrapper reports for a given nonce in the current scenario.
    function automatic logic [255:0] hash_for(input logic [31:0] n);
        logic [255:0] h;
        int k;
        case (hmode)
            HM_ONES:   h = '1;
            HM_TARGET: h = (n == htarget) ? htarget_hash : '1;
            HM_FIXED:  h = hfixed;
            default: begin
                k = int'(((n ^ hsalt) * 32'd13) % 32'd24);
                h = {8{(n * 32'h9E37_79B9) ^ hsalt}};
                h = h | (256'h1 << (255 - k));
                h = h & ({256{1'b1}} >> k);
            end
        endcase
        return h;
    endfunction

    function automatic int ref_lz(input logic [255:0] h);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
`ifdef HEADER_FEEDER_LE_CHECK_EN
        for (int b = 0; b < 32; b++)
            for (int i = 7; i >= 0; i--)
                if (!hit) begin
                    if (h[8*b + i]) hit = 1'b1;
                    else n++;
                end
`else
        for (int i = 255; i >= 0; i--)
            if (!hit) begin
                if (h[i]) hit = 1'b1;
                else n++;
            end
`endif
        return n;
    endfunction

    // Search the nonce space the way the controller should, with plain arithmetic.
    task automatic ref_run(input logic [31:0] init, input int z, output bit f, output bit ex,
                           output logic [31:0] n_out, output logic [255:0] h_out, output int iters);
        logic [31:0]  n;
        logic [255:0] h;
        bit           stop;
        n = init; iters = 0; f = 1'b0; ex = 1'b0; n_out = '0; h_out = '0; stop = 1'b0;
        while (!stop && iters < 2000) begin
            h = hash_for(n);
            iters++;
            if (ref_lz(h) >= z) begin
                f = 1'b1; n_out = n; h_out = h; stop = 1'b1;
            end else if (n == 32'hFFFF_FFFF) begin
                ex = 1'b1; n_out = n; h_out = h; stop = 1'b1;
            end else begin
                n = n + 32'd1;
            end
        end
    endtask

    // Behavioural wrapper: fetch words 0..19 (plus maybe one unmapped word), then report a hash.
    task automatic serve_job();
        logic [31:0] got19, exp;
        int waitc, addr;
        got19 = '0;
        for (int a = 0; a < 21; a++) begin
            addr = a;
            if (a == 20) begin
                if ($urandom_range(0, 1) == 0) break;
                addr = int'($urandom_range(20, 31));
            end
            exp = (addr == 19) ? exp_nonce : ((addr < 19) ? hdr_ref[addr] : 32'h0);
            bus.sha_rq = 1'b1;
            bus.sha_addr = 5'(addr);
            waitc = 0;
            do begin
                @(negedge clk);
                waitc++;
            end while (bus.sha_rdy !== 1'b1 && waitc < 8);
            bus.sha_rq = 1'b0;
            checks++;
            if (bus.sha_rdy !== 1'b1) begin
                errors++;
                $display("FAIL word_rdy addr=%0d: no sha_rdy within 8 cycles", addr);
            end else if (bus.sha_data !== exp) begin
                errors++;
                $display("FAIL word_data addr=%0d: got %h expected %h", addr, bus.sha_data, exp);
            end
            if (addr == 19) got19 = bus.sha_data;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        exp_nonce = exp_nonce + 32'd1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.sha_hash = hash_for(got19);
        bus.sha_done = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        bus.sha_done = 1'b0;
    endtask

    initial begin : wrapper
        bus.sha_rq = 1'b0;
        bus.sha_addr = '0;
        bus.sha_hash = '0;
        bus.sha_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.sha_start === 1'b1) begin
                n_starts++;
                if (wrap_auto) serve_job();
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic load_header();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 1)) begin
                bus.ld_valid = 1'b0;
                bus.ld_data = $urandom;
                @(negedge clk);
            end
            bus.ld_valid = 1'b1;
            bus.ld_data = hdr_ref[i];
            @(negedge clk);
            bus.ld_valid = 1'b0;
        end
        checks++;
        if (bus.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_load: ld_ready=%b expected 0", bus.ld_ready);
        end
    endtask

    task automatic do_abort(input string name);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({bus.ld_ready, busy, found, exhausted} !== 4'b1000) begin
            errors++;
            $display("FAIL %s abort_state: {ld_ready,busy,found,exhausted}=%b expected 1000",
                     name, {bus.ld_ready, busy, found, exhausted});
        end
    endtask

    // Full mining run with the automatic wrapper, compared against the reference search.
    task automatic run_case(input string name, input logic [31:0] init, input int z);
        bit           ef, eex;
        logic [31:0]  en;
        logic [255:0] eh;
        int           iters, waitc, lat;
        hdr_ref[19] = init;
        ref_run(init, z, ef, eex, en, eh, iters);
        load_header();
        exp_nonce = init;
        n_starts = 0;
        wrap_auto = 1'b1;
        zbits = 9'(z);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        zbits = 9'($urandom);
        checks++;
        if (bus.sha_start !== 1'b1) begin
            errors++;
            $display("FAIL %s go_to_start: sha_start=%b expected 1", name, bus.sha_start);
        end
        waitc = 0;
        while (found !== 1'b1 && exhausted !== 1'b1 && waitc < iters * 200 + 200) begin
            @(negedge clk);
            waitc++;
        end
        lat = cyc - done_cyc;
        checks++;
        if ({found, exhausted} !== {ef, eex}) begin
            errors++;
            $display("FAIL %s result_flags: {found,exhausted}=%b expected %b", name,
                     {found, exhausted}, {ef, eex});
        end
        checks++;
        if (nonce_out !== en) begin
            errors++;
            $display("FAIL %s nonce_out: got %h expected %h", name, nonce_out, en);
        end
        checks++;
        if (hash_out !== eh) begin
            errors++;
            $display("FAIL %s hash_out: got %h expected %h", name, hash_out, eh);
        end
        checks++;
        if (n_starts != iters) begin
            errors++;
            $display("FAIL %s start_count: got %0d expected %0d", name, n_starts, iters);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL %s done_to_result: got %0d cycles expected 2", name, lat);
        end
        // DONE must ignore go and hold its result.
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_starts != iters || busy !== 1'b0 || {found, exhausted} !== {ef, eex} || nonce_out !== en) begin
            errors++;
            $display("FAIL %s done_hold: starts=%0d busy=%b flags=%b nonce=%h expected starts=%0d busy=0 flags=%b nonce=%h",
                     name, n_starts, busy, {found, exhausted}, nonce_out, iters, {ef, eex}, en);
        end
        do_abort(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; abort = 1'b0; zbits = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ld_ready, bus.sha_start, bus.sha_rdy, busy, found, exhausted} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: {ld_ready,sha_start,sha_rdy,busy,found,exhausted}=%b expected 000000",
                     {bus.ld_ready, bus.sha_start, bus.sha_rdy, busy, found, exhausted});
        end
        checks++;
        if (bus.sha_data !== 32'h0 || nonce_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_words: sha_data=%h nonce_out=%h expected 0", bus.sha_data, nonce_out);
        end
        checks++;
        if (hash_out !== 256'h0) begin
            errors++;
            $display("FAIL reset_hash: hash_out=%h expected 0", hash_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ld_ready=%b expected 1", bus.ld_ready);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 20; i++) hdr_ref[i] = 32'(i);
        hmode = HM_ONES;
        run_case("basic", 32'h0000_0013, 0);
    endtask

    task automatic test_target();
        for (int i = 0; i < 19; i++) hdr_ref[i] = $urandom;
        hmode = HM_TARGET;
        htarget = 32'h0000_0105;
`ifdef HEADER_FEEDER_LE_CHECK_EN
        htarget_hash = 256'h1 << 248;
`else
        htarget_hash = 256'h1;
`endif
        run_case("target", 32'h0000_0100, 255);
    endtask

    task automatic test_exhaust();
        for (int i = 0; i < 19; i++) hdr_ref[i] = $urandom;
        hmode = HM_ONES;
        run_case("exhaust", 32'hFFFF_FFFE, 256);
    endtask

    task automatic test_byte_order();
        for (int i = 0; i < 19; i++) hdr_ref[i] = $urandom;
        hmode = HM_FIXED;
        hfixed = {{30{8'hFF}}, 8'h0F, 8'h00};
        run_case("byte_order", 32'hFFFF_FFFE, 12);
    endtask

    // Manual wrapper: held request, unmapped word, unqualified done, abort and stale result.
    task automatic test_rq_hold_abort();
        int pulses, waitc;
        for (int i = 0; i < 20; i++) hdr_ref[i] = $urandom;
        load_header();
        wrap_auto = 1'b0;
        n_starts = 0;
        zbits = '0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        bus.sha_rq = 1'b1;
        bus.sha_addr = 5'd3;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.sha_rdy === 1'b1) begin
                pulses++;
                checks++;
                if (bus.sha_data !== hdr_ref[3]) begin
                    errors++;
                    $display("FAIL hold_data: got %h expected %h", bus.sha_data, hdr_ref[3]);
                end
            end
        end
        bus.sha_rq = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.sha_rdy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL hold_pulses: got %0d expected 1", pulses);
        end
        bus.sha_rq = 1'b1;
        bus.sha_addr = 5'd27;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (bus.sha_rdy !== 1'b1 && waitc < 8);
        bus.sha_rq = 1'b0;
        checks++;
        if (bus.sha_rdy !== 1'b1 || bus.sha_data !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_word: rdy=%b data=%h expected rdy=1 data=0", bus.sha_rdy, bus.sha_data);
        end
        @(negedge clk);
        bus.sha_hash = '0;
        bus.sha_done = 1'b1;
        @(negedge clk);
        bus.sha_done = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (found !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_before_19: found=%b busy=%b expected found=0 busy=1", found, busy);
        end
        bus.sha_rq = 1'b1;
        bus.sha_addr = 5'd19;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (bus.sha_rdy !== 1'b1 && waitc < 8);
        bus.sha_rq = 1'b0;
        checks++;
        if (bus.sha_rdy !== 1'b1 || bus.sha_data !== hdr_ref[19]) begin
            errors++;
            $display("FAIL nonce_word: rdy=%b data=%h expected rdy=1 data=%h", bus.sha_rdy, bus.sha_data, hdr_ref[19]);
        end
        @(negedge clk);
        do_abort("mid_run");
        bus.sha_hash = '0;
        bus.sha_done = 1'b1;
        @(negedge clk);
        bus.sha_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({found, exhausted, bus.ld_ready} !== 3'b001) begin
            errors++;
            $display("FAIL stale_done: {found,exhausted,ld_ready}=%b expected 001", {found, exhausted, bus.ld_ready});
        end
        bus.sha_rq = 1'b1;
        bus.sha_addr = 5'd2;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.sha_rdy === 1'b1) pulses++;
        end
        bus.sha_rq = 1'b0;
        checks++;
        if (pulses != 0 || n_starts != 1) begin
            errors++;
            $display("FAIL rq_outside_run: pulses=%0d starts=%0d expected 0 and 1", pulses, n_starts);
        end
        @(negedge clk);
        wrap_auto = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0]  init, en;
        logic [255:0] eh;
        bit           ef, eex;
        int           z, iters;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 19; i++) hdr_ref[i] = $urandom;
            hmode = HM_RAND;
            hsalt = $urandom;
            init = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom;
`ifdef HEADER_FEEDER_LE_CHECK_EN
            z = int'($urandom_range(0, 3));
`else
            z = int'($urandom_range(0, 14));
`endif
            if (init > 32'hFFFF_FFF0 && $urandom_range(0, 1) == 1) z = 257 + int'($urandom_range(0, 200));
            ref_run(init, z, ef, eex, en, eh, iters);
            if (iters > 30) z = 0;
            run_case("random", init, z);
        end
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_target();
        test_exhaust();
        test_byte_order();
        test_rq_hold_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
